keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Row-scanning controller for the 4x4 matrix keypad. Drives one row at a time and samples the four column lines through a synchroniser. A key is accepted only when exactly one column is active and stays stable for a programmable number of scan ticks. The accepted key is presented as one-hot row/col plus a press strobe, ready for the team's row/col key decoder and the calculator entry logic downstream.

## Interface
- `SCAN_DIV`, 1000: clock cycles per row slot (scan tick period); must be ≥ 2.
- `DEBOUNCE_TICKS`, 4: consecutive matching ticks needed to accept a press or a release; must be ≥ 1.
- `REPEAT_TICKS`, 64: ticks between auto-repeat strobes (used only with the macro).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `col_sense`  in  4  raw column lines, active-high, asynchronous to `clk`.
- `row_drive`  out  4  one-hot row drive, active-high.
- `key_row`  out  4  one-hot row of the accepted key; 0 when none.
- `key_col`  out  4  one-hot column of the accepted key; 0 when none.
- `key_valid`  out  1  level signal; high while an accepted key is held (through the HELD and RELEASE states).
- `key_strobe`  out  1  one-cycle pulse per accepted press (and per repeat).

## Operation
- `col_sense` passes through a 2-flop synchroniser; all decisions use the synchronised value `cs`.
- A free-running divider counts 0..`SCAN_DIV`-1. `tick` is the cycle where the count equals `SCAN_DIV`-1.
- Sampling happens only on `tick`.
- FSM states: SCAN, DEBOUNCE, HELD, RELEASE.
- **SCAN**
  - On `tick`, if `cs` is one-hot: capture `cand_row`=`row_drive` and `cand_col`=`cs`, clear the debounce count, go to DEBOUNCE, and hold `row_drive`.
  - Otherwise rotate `row_drive` left (0001→0010→0100→1000→0001).
  - `cs` with two or more bits set (ghost or multi-key) is treated as no key.
- **DEBOUNCE**
  - On `tick`, if `cs`==`cand_col`, increment the count. On reaching `DEBOUNCE_TICKS`: go to HELD, load `key_row`/`key_col`, and assert `key_valid` and `key_strobe`.
  - On mismatch, go to SCAN and rotate the row. No outputs change.
- **HELD**
  - On `tick`, if `cs`!=`cand_col`, go to RELEASE and clear the count.
- **RELEASE**
  - On `tick`, if `cs`==0, increment the count. On reaching `DEBOUNCE_TICKS`: clear `key_valid`, `key_row` and `key_col`, go to SCAN, and rotate the row.
  - If `cs`==`cand_col`, return to HELD with no strobe.
  - Any other value clears the count.
- The debounce count is `$clog2(DEBOUNCE_TICKS+1)` bits wide and saturates, so it never wraps.

## Timing
- Reset values (asynchronous): `row_drive`=0001, `key_row`=0, `key_col`=0, `key_valid`=0, `key_strobe`=0. State=SCAN, divider=0, counts=0.
- All outputs are registered.
- `key_strobe` and the rising edge of `key_valid` occur together, in the cycle after the tick that completes debounce.
- `key_strobe` is high for exactly 1 cycle.
- Input-to-sample latency: 2 synchroniser cycles plus up to `SCAN_DIV` cycles to the next tick.
- Minimum press-to-strobe time: (`DEBOUNCE_TICKS`+1) ticks after the capture tick's row slot begins; a full scan is 4 ticks.
- `row_drive` changes only in the cycle after a tick, so it is stable across the whole slot.
- Reset asserted mid-operation (any state) forces the reset values immediately. Scanning restarts at row 0001 with divider 0 after `rst` falls.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined: in HELD, a repeat counter increments on each matching tick. On reaching `REPEAT_TICKS` it pulses `key_strobe` for one cycle and restarts. The counter clears on entry to HELD, including re-entry from RELEASE.
- Not defined: exactly one `key_strobe` per accepted press, the repeat counter is not instantiated, and `REPEAT_TICKS` is ignored.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum (`SCAN`, `DEBOUNCE`, `HELD`, `RELEASE`);
  - the one-hot row constants `ROW0`..`ROW3`;
  - a function `is_onehot4`;
  - the default parameter values.
- One sub-module, `keypad_scan_timer`: parameterised divider producing `tick`, with asynchronous reset. The synchroniser and FSM stay in the top module.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_TICKS`=3, `REPEAT_TICKS`=5. The keypad model drives `col_sense`=0010 only while `row_drive`=0100.
- Clean press held for 40 ticks, then release → exactly one `key_strobe`; `key_row`=0100, `key_col`=0010. `key_valid` stays high until 3 ticks after release, then outputs return to 0.
- Bounce: the key drops after 1 matching DEBOUNCE tick → no strobe, `key_valid` stays 0, and the next `row_drive` is 1000.
- Two keys in the same row (`col_sense`=0011 on row 0100) → no strobe; `row_drive` keeps rotating every 4 cycles.
- Release glitch: in RELEASE, `cs` returns to 0010 after 1 zero tick → back to HELD, `key_valid` stays 1, no new strobe.
- With `KEYPAD_AUTOREPEAT_EN`, key held for 20 ticks after acceptance → strobes at acceptance and after HELD ticks 5, 10, 15, 20 (5 total). Without the macro → 1 strobe.
- `rst` pulsed while in HELD → `key_valid`, `key_row` and `key_col` are 0 asynchronously, `row_drive`=0001, and the scan resumes cleanly.

Source files
------------

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types, row constants and defaults for the 4x4 keypad row-scanning controller.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] ROW0 = 4'b0001;
  localparam logic [3:0] ROW1 = 4'b0010;
  localparam logic [3:0] ROW2 = 4'b0100;
  localparam logic [3:0] ROW3 = 4'b1000;

  localparam int unsigned SCAN_DIV_DEF       = 1000;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 4;
  localparam int unsigned REPEAT_TICKS_DEF   = 64;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // An illegal (non-one-hot) row value recovers to ROW0.
  function automatic logic [3:0] next_row(input logic [3:0] r);
    case (r)
      ROW0:    return ROW1;
      ROW1:    return ROW2;
      ROW2:    return ROW3;
      default: return ROW0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad-side signal bundle: row drive / column sense plus the accepted-key outputs.
interface keypad_if;
  logic [3:0] col_sense;
  logic [3:0] row_drive;
  logic [3:0] key_row;
  logic [3:0] key_col;
  logic       key_valid;
  logic       key_strobe;

  modport master (
    input  col_sense,
    output row_drive, key_row, key_col, key_valid, key_strobe
  );

  modport slave (
    output col_sense,
    input  row_drive, key_row, key_col, key_valid, key_strobe
  );
endinterface

// File: rtl/keypad_scan_timer.sv
// Free-running divider 0..SCAN_DIV-1; tick_o is high in the cycle the count is SCAN_DIV-1.
module keypad_scan_timer
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int unsigned   CW   = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == LAST) ? '0 : div_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  assign tick_o = (div_q == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad row scanner with column debounce and one-hot key outputs.
// Define KEYPAD_AUTOREPEAT_EN to emit a repeat strobe every REPEAT_TICKS held ticks.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = SCAN_DIV_DEF,
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
  parameter int unsigned REPEAT_TICKS   = REPEAT_TICKS_DEF
) (
  input  logic     clk,
  input  logic     rst,
  keypad_if.master kp
);

  if (SCAN_DIV < 2 || DEBOUNCE_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_err
    $error("keypad_scan_ctrl: SCAN_DIV must be >= 2, tick counts >= 1");
  end

  localparam int unsigned   DW  = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DW-1:0] DEB = DW'(DEBOUNCE_TICKS);

  function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
    return (v == DEB) ? v : v + DW'(1);
  endfunction

  logic [3:0] cs_meta_q, cs_q;
  logic       tick;

  kp_state_e     state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [3:0]    cand_row_q, cand_row_d;
  logic [3:0]    cand_col_q, cand_col_d;
  logic [DW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    key_row_q, key_row_d;
  logic [3:0]    key_col_q, key_col_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned   RW  = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP = RW'(REPEAT_TICKS);
  logic [RW-1:0] rep_q, rep_d, rep_inc;
  assign rep_inc = rep_q + RW'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta_q <= '0;
      cs_q      <= '0;
    end else begin
      cs_meta_q <= kp.col_sense;
      cs_q      <= cs_meta_q;
    end
  end

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  assign cnt_inc = sat_inc(cnt_q);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cand_row_d = cand_row_q;
    cand_col_d = cand_col_q;
    cnt_d      = cnt_q;
    key_row_d  = key_row_q;
    key_col_d  = key_col_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d      = rep_q;
`endif
    if (tick) begin
      case (state_q)
        SCAN: begin
          // Multi-bit columns (ghosting / two keys) count as no key.
          if (is_onehot4(cs_q)) begin
            cand_row_d = row_q;
            cand_col_d = cs_q;
            cnt_d      = '0;
            state_d    = DEBOUNCE;
          end else begin
            row_d = next_row(row_q);
          end
        end
        DEBOUNCE: begin
          if (cs_q == cand_col_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              state_d   = HELD;
              key_row_d = cand_row_q;
              key_col_d = cand_col_q;
              valid_d   = 1'b1;
              strobe_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
              rep_d     = '0;
`endif
            end
          end else begin
            state_d = SCAN;
            row_d   = next_row(row_q);
          end
        end
        HELD: begin
          if (cs_q != cand_col_q) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_inc == REP) begin
            strobe_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_inc;
          end
`endif
        end
        RELEASE: begin
          if (cs_q == 4'b0000) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB) begin
              valid_d   = 1'b0;
              key_row_d = '0;
              key_col_d = '0;
              state_d   = SCAN;
              row_d     = next_row(row_q);
            end
          end else if (cs_q == cand_col_q) begin
            state_d = HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= SCAN;
      row_q     <= ROW0;
      cnt_q     <= '0;
      key_row_q <= '0;
      key_col_q <= '0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      key_row_q <= key_row_d;
      key_col_q <= key_col_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  // Candidate key is only consulted after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    cand_row_q <= cand_row_d;
    cand_col_q <= cand_col_d;
  end

  assign kp.row_drive  = row_q;
  assign kp.key_row    = key_row_q;
  assign kp.key_col    = key_col_q;
  assign kp.key_valid  = valid_q;
  assign kp.key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: table of press/release steps plus corner-case sequences.
module tb_keypad_scan_ctrl;
  import keypad_pkg::*;

  localparam int unsigned SD = 4;
  localparam int unsigned DT = 3;
  localparam int unsigned RT = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] pat = 4'b0000;

  keypad_if kp_bus();

  keypad_scan_ctrl #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_TICKS (DT),
    .REPEAT_TICKS   (RT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_bus)
  );

  always #5 clk = ~clk;

  // The only key on the pad sits in row 0100.
  assign kp_bus.col_sense = (kp_bus.row_drive == 4'b0100) ? pat : 4'b0000;

  int strobe_cnt = 0;
  always @(negedge clk) if (kp_bus.key_strobe) strobe_cnt <= strobe_cnt + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n * SD) @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [3:0] kr,
                          input logic [3:0] kc, input logic [3:0] rd);
    chk({tag, ".valid"}, int'(kp_bus.key_valid), int'(v));
    chk({tag, ".key_row"}, int'(kp_bus.key_row), int'(kr));
    chk({tag, ".key_col"}, int'(kp_bus.key_col), int'(kc));
    chk({tag, ".row_drive"}, int'(kp_bus.row_drive), int'(rd));
  endtask

  typedef struct {
    logic [3:0] pat;
    int         ticks;
    int         strobes;
    logic       valid;
    logic [3:0] krow;
    logic [3:0] kcol;
    logic [3:0] rdrive;
  } step_t;

  step_t steps [4];

  initial begin
    int         s0;
    logic [3:0] exp_row;
    string      tag;

`ifdef KEYPAD_AUTOREPEAT_EN
    steps[0] = '{4'b0010, 40, 7, 1'b1, 4'b0100, 4'b0010, 4'b0100};
`else
    steps[0] = '{4'b0010, 40, 1, 1'b1, 4'b0100, 4'b0010, 4'b0100};
`endif
    steps[1] = '{4'b0000, 3, 0, 1'b1, 4'b0100, 4'b0010, 4'b0100};
    steps[2] = '{4'b0000, 1, 0, 1'b0, 4'b0000, 4'b0000, 4'b1000};
    steps[3] = '{4'b0011, 4, 0, 1'b0, 4'b0000, 4'b0000, 4'b1000};

    #1 rst = 1'b1;
    #20;
    chk_outs("reset", 1'b0, 4'b0000, 4'b0000, 4'b0001);
    chk("reset.strobe", int'(kp_bus.key_strobe), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tag = $sformatf("step%0d", i);
      pat = steps[i].pat;
      s0  = strobe_cnt;
      run_ticks(steps[i].ticks);
      chk({tag, ".strobes"}, strobe_cnt - s0, steps[i].strobes);
      chk_outs(tag, steps[i].valid, steps[i].krow, steps[i].kcol, steps[i].rdrive);
    end

    // Two keys in row 0100: scanning must keep rotating every tick.
    exp_row = 4'b1000;
    s0 = strobe_cnt;
    for (int i = 0; i < 8; i++) begin
      run_ticks(1);
      exp_row = {exp_row[2:0], exp_row[3]};
      chk($sformatf("multikey.row%0d", i), int'(kp_bus.row_drive), int'(exp_row));
    end
    chk("multikey.strobes", strobe_cnt - s0, 0);
    chk("multikey.valid", int'(kp_bus.key_valid), 0);

    // Bounce: capture, one matching tick, then the key drops.
    pat = 4'b0010;
    s0  = strobe_cnt;
    run_ticks(5);
    chk_outs("bounce.debounce", 1'b0, 4'b0000, 4'b0000, 4'b0100);
    pat = 4'b0000;
    run_ticks(1);
    chk_outs("bounce.drop", 1'b0, 4'b0000, 4'b0000, 4'b1000);
    chk("bounce.strobes", strobe_cnt - s0, 0);

    // Release glitch: one zero tick, then the key is seen again.
    pat = 4'b0010;
    s0  = strobe_cnt;
    run_ticks(7);
    chk("glitch.accept_strobes", strobe_cnt - s0, 1);
    chk_outs("glitch.accept", 1'b1, 4'b0100, 4'b0010, 4'b0100);
    s0  = strobe_cnt;
    pat = 4'b0000;
    run_ticks(2);
    chk("glitch.release_valid", int'(kp_bus.key_valid), 1);
    pat = 4'b0010;
    run_ticks(1);
    chk_outs("glitch.back_held", 1'b1, 4'b0100, 4'b0010, 4'b0100);
    pat = 4'b0000;
    run_ticks(3);
    chk("glitch.late_valid", int'(kp_bus.key_valid), 1);
    run_ticks(1);
    chk_outs("glitch.done", 1'b0, 4'b0000, 4'b0000, 4'b1000);
    chk("glitch.strobes", strobe_cnt - s0, 0);

    // Long hold after acceptance: repeats only with auto-repeat built in.
    pat = 4'b0010;
    s0  = strobe_cnt;
    run_ticks(7);
    chk("hold.accept_strobes", strobe_cnt - s0, 1);
    s0 = strobe_cnt;
    run_ticks(20);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("hold.repeat_strobes", strobe_cnt - s0, 4);
`else
    chk("hold.repeat_strobes", strobe_cnt - s0, 0);
`endif
    chk("hold.valid", int'(kp_bus.key_valid), 1);

    // Asynchronous reset while HELD, away from any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_outs("async_rst", 1'b0, 4'b0000, 4'b0000, 4'b0001);
    chk("async_rst.strobe", int'(kp_bus.key_strobe), 0);
    @(negedge clk);
    rst = 1'b0;
    s0  = strobe_cnt;
    run_ticks(1);
    chk("resume.row", int'(kp_bus.row_drive), int'(4'b0010));
    run_ticks(5);
    chk("resume.strobes", strobe_cnt - s0, 1);
    chk_outs("resume", 1'b1, 4'b0100, 4'b0010, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
